mono_sample_to_packet_converter: RTL

Transmit-side counterpart of the stereo-to-mono receive path. The block accepts single mono samples on a valid-qualified strobe, buffers them in a small FIFO, and emits each one as a two-beat AXI4-Stream stereo packet toward the audio output path. Beat 0 is left and beat 1 is right, both carrying the mono value, with TLAST on beat 1.

---
 rtl/mono_sample_to_packet_converter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mono_sample_to_packet_converter.sv
// Buffers strobed mono samples in a small FIFO and replays each one as a
// two-beat AXI4-Stream stereo packet (left, then right with TLAST).
module mono_sample_to_packet_converter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          M_AXIS_ACLK,
    input  logic                          M_AXIS_ARESETN,
    input  logic                          mono_sample_valid,
    input  logic [DATA_WIDTH-1:0]         mono_sample,
    output logic                          M_AXIS_TVALID,
    output logic                          M_AXIS_TLAST,
    output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
    input  logic                          M_AXIS_TREADY,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  overflow_q, overflow_d;

    logic                  hs;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic [DATA_WIDTH-1:0] head;

    assign head = mem_q[rd_ptr_q];
    assign hs   = tvalid_q && M_AXIS_TREADY;
    assign full = (level_q == LW'(FIFO_DEPTH));

    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        hold_d   = hold_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = head;
                    hold_d   = head;
                    state_d  = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (hs) begin
                    tdata_d = hold_q;
                    tlast_d = 1'b1;
                    state_d = ST_RIGHT;
                end
            end
            ST_RIGHT: begin
                if (hs) begin
                    if (level_q != '0) begin
                        // Back-to-back: next packet's left beat follows with no bubble.
                        pop     = 1'b1;
                        tlast_d = 1'b0;
                        tdata_d = head;
                        hold_d  = head;
                        state_d = ST_LEFT;
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A full FIFO still accepts a sample when the head leaves on the same edge.
        push       = mono_sample_valid && (!full || pop);
        overflow_d = overflow_q || (mono_sample_valid && full && !pop);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            hold_q     <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            hold_q     <= hold_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= mono_sample;
        end
    end

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign fifo_level    = level_q;
    assign overflow      = overflow_q;

endmodule
